// File: rtl/disp_share_arbiter.sv
// Round-robin display arbiter with minimum hold time and urgent preemption.
// The granted requester's digits/decimal points are forwarded, registered, to the display controller.
module disp_share_arbiter #(
  parameter int NREQ     = 4,
  parameter int HOLD_CYC = 100_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      urgent,
  input  logic [32*NREQ-1:0]   digits_in,
  input  logic [8*NREQ-1:0]    dp_in,
  output logic [31:0]          digits,
  output logic [7:0]           dps,
  output logic [NREQ-1:0]      grant,
  output logic                 active,
  output logic [NREQ-1:0]      done,
  output logic                 dbg_state
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  typedef enum logic {ST_IDLE = 1'b0, ST_SHOW = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic            urg_q, urg_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [31:0]     digits_q, digits_d;
  logic [7:0]      dps_q, dps_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            active_q, active_d;

  logic [NREQ-1:0] urg_req, pre_req;
  logic            win_valid, win_urg, pre_valid;
  logic [IW-1:0]   win_idx, pre_idx;
  logic            owner_req, expire, preempt;
  logic [31:0]     sel_digits;
  logic [7:0]      sel_dps;
  int              j;

  // Winner: lowest urgent requester, else first req after the RR pointer (wrapping).
  always_comb begin
    urg_req   = req & urgent;
    pre_req   = urg_req & ~grant_q;
    win_valid = |req;
    win_urg   = |urg_req;
    pre_valid = |pre_req;
    win_idx   = '0;
    pre_idx   = '0;
    j         = 0;
    if (win_urg) begin
      for (int i = NREQ - 1; i >= 0; i--)
        if (urg_req[i]) win_idx = IW'(i);
    end else begin
      for (int k = NREQ; k >= 1; k--) begin
        j = int'(rr_q) + k;
        if (j >= NREQ) j = j - NREQ;
        if (req[j]) win_idx = IW'(j);
      end
    end
    for (int i = NREQ - 1; i >= 0; i--)
      if (pre_req[i]) pre_idx = IW'(i);
  end

  always_comb begin
    owner_req  = 1'b0;
    sel_digits = '0;
    sel_dps    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q == IW'(i)) begin
        owner_req  = req[i];
        sel_digits = digits_in[32*i +: 32];
        sel_dps    = dp_in[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    urg_d   = urg_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    done_d  = '0;
    expire  = (state_q == ST_SHOW) && (cnt_q == CW'(HOLD_CYC - 1));
    preempt = (state_q == ST_SHOW) && !urg_q && pre_valid;
    case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          state_d = ST_SHOW;
          owner_d = win_idx;
          urg_d   = win_urg;
          cnt_d   = '0;
          rr_d    = win_idx;
        end
      end
      ST_SHOW: begin
        // Expiry outranks release and preemption so done still fires when they coincide.
        if (expire || !owner_req) begin
          if (expire) done_d = grant_q;
          cnt_d = '0;
          if (win_valid) begin
            owner_d = win_idx;
            urg_d   = win_urg;
            rr_d    = win_idx;
          end else begin
            state_d = ST_IDLE;
            urg_d   = 1'b0;
          end
        end else if (preempt) begin
          owner_d = pre_idx;
          urg_d   = 1'b1;
          cnt_d   = '0;
          rr_d    = pre_idx;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    active_d = (state_d == ST_SHOW);
    grant_d  = '0;
    for (int i = 0; i < NREQ; i++)
      grant_d[i] = (state_d == ST_SHOW) && (owner_d == IW'(i));
    // Data follows the current owner one cycle behind grant; blanked as soon as we go idle.
    if ((state_q == ST_SHOW) && (state_d == ST_SHOW)) begin
      digits_d = sel_digits;
      dps_d    = sel_dps;
    end else begin
      digits_d = '0;
      dps_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      urg_q    <= 1'b0;
      cnt_q    <= '0;
      rr_q     <= IW'(NREQ - 1);
      digits_q <= '0;
      dps_q    <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      urg_q    <= urg_d;
      cnt_q    <= cnt_d;
      rr_q     <= rr_d;
      digits_q <= digits_d;
      dps_q    <= dps_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      active_q <= active_d;
    end
  end

  assign digits    = digits_q;
  assign dps       = dps_q;
  assign grant     = grant_q;
  assign active    = active_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_disp_share_arbiter.sv
// Directed bench for disp_share_arbiter with NREQ = 4 and HOLD_CYC = 10.
module tb_disp_share_arbiter;

  localparam int NREQ = 4;
  localparam int HOLD = 10;

  logic                clk;
  logic                reset;
  logic [NREQ-1:0]     req;
  logic [NREQ-1:0]     urgent;
  logic [32*NREQ-1:0]  digits_in;
  logic [8*NREQ-1:0]   dp_in;
  logic [31:0]         digits;
  logic [7:0]          dps;
  logic [NREQ-1:0]     grant;
  logic                active;
  logic [NREQ-1:0]     done;
  logic                dbg_state;

  int n_cmp;
  int n_mis;

  disp_share_arbiter #(.NREQ(NREQ), .HOLD_CYC(HOLD)) dut (
    .clk(clk), .reset(reset), .req(req), .urgent(urgent),
    .digits_in(digits_in), .dp_in(dp_in), .digits(digits), .dps(dps),
    .grant(grant), .active(active), .done(done), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    req = '0;
    urgent = '0;
    repeat (2) tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int c = 0; c < 20; c++) begin
      n_cmp++;
      if (grant !== 4'b0000 || active !== 1'b0 || digits !== 32'h0) begin
        n_mis++;
        $display("FAIL idle_c%0d grant=%b active=%b digits=%h required 0/0/0", c, grant, active, digits);
      end
      tick();
    end
    digits_in[95:64] = 32'h12345678;
    dp_in[23:16] = 8'hA5;
    req = 4'b0100;
    tick();
    n_cmp++;
    if (grant !== 4'b0100 || active !== 1'b1 || digits !== 32'h0) begin
      n_mis++;
      $display("FAIL first_grant grant=%b active=%b digits=%h required 0100/1/0", grant, active, digits);
    end
    tick();
    n_cmp++;
    if (digits !== 32'h12345678 || dps !== 8'hA5) begin
      n_mis++;
      $display("FAIL first_data digits=%h dps=%h required 12345678/a5", digits, dps);
    end
    digits_in[95:64] = 32'hCAFE0001;
    tick();
    n_cmp++;
    if (digits !== 32'hCAFE0001) begin
      n_mis++;
      $display("FAIL live_data digits=%h required cafe0001", digits);
    end
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] seq [4];
    logic [NREQ-1:0] exp_done;
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b1000; seq[3] = 4'b0001;
    apply_reset();
    req = 4'b1011;
    tick();
    for (int g = 0; g < 4; g++) begin
      for (int c = 0; c < HOLD; c++) begin
        exp_done = (c == 0 && g > 0) ? seq[g-1] : 4'b0000;
        n_cmp++;
        if (grant !== seq[g] || done !== exp_done) begin
          n_mis++;
          $display("FAIL rr_g%0d_c%0d grant=%b done=%b required %b/%b", g, c, grant, done, seq[g], exp_done);
        end
        tick();
      end
    end
  endtask

  task automatic test_single_requester();
    logic [NREQ-1:0] exp_done;
    apply_reset();
    req = 4'b0001;
    tick();
    for (int c = 0; c < 3 * HOLD + 1; c++) begin
      exp_done = (c > 0 && (c % HOLD) == 0) ? 4'b0001 : 4'b0000;
      n_cmp++;
      if (grant !== 4'b0001 || active !== 1'b1 || done !== exp_done) begin
        n_mis++;
        $display("FAIL single_c%0d grant=%b active=%b done=%b required 0001/1/%b", c, grant, active, done, exp_done);
      end
      tick();
    end
  endtask

  task automatic test_preempt();
    apply_reset();
    req = 4'b0001;
    tick();
    repeat (3) tick();
    req = 4'b0101;
    urgent = 4'b0100;
    tick();
    n_cmp++;
    if (grant !== 4'b0100 || done !== 4'b0000) begin
      n_mis++;
      $display("FAIL preempt grant=%b done=%b required 0100/0000", grant, done);
    end
    req = 4'b0111;
    urgent = 4'b0110;
    for (int c = 1; c < HOLD; c++) begin
      tick();
      n_cmp++;
      if (grant !== 4'b0100 || done !== 4'b0000) begin
        n_mis++;
        $display("FAIL no_preempt_c%0d grant=%b done=%b required 0100/0000", c, grant, done);
      end
    end
    tick();
    n_cmp++;
    if (grant !== 4'b0010 || done !== 4'b0100) begin
      n_mis++;
      $display("FAIL urgent_after_hold grant=%b done=%b required 0010/0100", grant, done);
    end
    urgent = '0;
  endtask

  task automatic test_early_release();
    apply_reset();
    digits_in[63:32] = 32'h0BADF00D;
    req = 4'b0010;
    tick();
    repeat (5) tick();
    n_cmp++;
    if (digits !== 32'h0BADF00D) begin
      n_mis++;
      $display("FAIL release_data digits=%h required 0badf00d", digits);
    end
    req = 4'b0000;
    tick();
    n_cmp++;
    if (grant !== 4'b0000 || active !== 1'b0 || digits !== 32'h0 || done !== 4'b0000) begin
      n_mis++;
      $display("FAIL release grant=%b active=%b digits=%h done=%b required 0/0/0/0", grant, active, digits, done);
    end
  endtask

  task automatic test_expire_drop();
    apply_reset();
    req = 4'b0001;
    tick();
    repeat (HOLD - 1) tick();
    req = 4'b0000;
    tick();
    n_cmp++;
    if (done !== 4'b0001 || grant !== 4'b0000 || active !== 1'b0) begin
      n_mis++;
      $display("FAIL expire_drop done=%b grant=%b active=%b required 0001/0000/0", done, grant, active);
    end
    tick();
    n_cmp++;
    if (done !== 4'b0000) begin
      n_mis++;
      $display("FAIL done_one_cycle done=%b required 0000", done);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    digits_in[63:32] = 32'h55AA55AA;
    dp_in[15:8] = 8'hFF;
    req = 4'b0010;
    tick();
    repeat (4) tick();
    #3;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (grant !== 4'b0000 || active !== 1'b0 || digits !== 32'h0 || dps !== 8'h0 || done !== 4'b0000) begin
      n_mis++;
      $display("FAIL async_reset grant=%b active=%b digits=%h dps=%h done=%b required zeros", grant, active, digits, dps, done);
    end
    req = 4'b0110;
    #2;
    reset = 1'b1;
    tick();
    n_cmp++;
    if (grant !== 4'b0010) begin
      n_mis++;
      $display("FAIL rr_after_reset grant=%b required 0010", grant);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    reset = 1'b0;
    req = '0;
    urgent = '0;
    digits_in = '0;
    dp_in = '0;
    test_reset();
    test_round_robin();
    test_single_requester();
    test_preempt();
    test_early_release();
    test_expire_drop();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
